// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Grants are burst-locked, capped at MAXBURST beats, and throttled by w_full.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int MAXBURST  = 4,
  localparam int IDW      = $clog2(NREQ),
  localparam int CW       = $clog2(MAXBURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      w_full,
  output logic                      w_en,
  output logic [DATAWIDTH-1:0]      w_data,
  output logic [NREQ-1:0]           grant,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic [0:0]                fsm_state
);

  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_GRANT = 1'b1;
  localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  CNT_CAP  = CW'(MAXBURST - 1);

  logic [0:0]           state;
  logic [IDW-1:0]       last_winner;
  logic [CW-1:0]        cnt;
  logic [IDW-1:0]       pick_id;
  logic                 pick_found;
  logic [IDW:0]         scan;
  logic                 owner_valid;
  logic                 owner_last;
  logic                 beat;
  logic                 release_now;
  logic [DATAWIDTH-1:0] sel_data;

  assign fsm_state = state;

  // Scan from the requester after the last winner, wrapping around.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    scan       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, last_winner} + (IDW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!pick_found && req_valid[scan[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan[IDW-1:0];
      end
    end
  end

  // grant is one-hot or zero, so an OR-mux selects the owner's data.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_data = sel_data | req_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Handshake: a beat transfers when the owner's req_valid and req_ready are
  // both high; req_ready is !w_full for the owner only, and a beat is w_en.
  assign owner_valid = |(req_valid & grant);
  assign owner_last  = |(req_last & grant);
  assign beat        = busy && owner_valid && !w_full && !rst;
  assign req_ready   = (busy && !w_full && !rst) ? grant : '0;
  assign w_en        = beat;
  assign w_data      = sel_data;
  assign release_now = !owner_valid || (beat && (owner_last || cnt == CNT_CAP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      last_winner <= LAST_RST;
    end else if (state == ST_IDLE) begin
      if (pick_found) begin
        state    <= ST_GRANT;
        grant    <= NREQ'(1) << pick_id;
        grant_id <= pick_id;
        busy     <= 1'b1;
        cnt      <= '0;
      end
    end else begin
      if (release_now) begin
        state       <= ST_IDLE;
        last_winner <= grant_id;
        grant       <= '0;
        busy        <= 1'b0;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Single-clock round-robin arbiter that shares one FIFO write port among NREQ requesters.
- Issues burst-locked grants and drives w_en/w_data into the FIFO write side.
- Throttles on the FIFO's w_full.
- Sits in the w_clk domain in front of the asyn_fifo_xlx write port.

Parameters:
NREQ, 4, number of requesters (2..8)
DATAWIDTH, 8, data width per requester and FIFO word width
MAXBURST, 4, max beats per grant before forced release (1..16)

Ports:
clk  in  1  clock (FIFO w_clk)
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester data valid
req_last  in  NREQ  per-requester last beat of packet
req_data  in  NREQ*DATAWIDTH  requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
req_ready  out  NREQ  per-requester accept, one-hot or zero
w_full  in  1  FIFO full
w_en  out  1  FIFO write enable
w_data  out  DATAWIDTH  FIFO write data
grant  out  NREQ  registered one-hot current owner, zero when idle
grant_id  out  clog2(NREQ)  binary index of owner, valid when busy
busy  out  1  a grant is held

Behaviour:
- Reset values (rst=1 at posedge clk):
  - grant=0, grant_id=0, busy=0.
  - Burst counter=0.
  - Last-winner pointer=NREQ-1, so requester 0 has highest priority first.
  - req_ready and w_en are forced 0 while rst=1.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any req_valid, pick the first set bit scanning from (last_winner+1) mod NREQ upward, with wrap.
  - Register it into grant/grant_id, set busy=1, clear the burst counter, go to GRANT.
  - Arbitration latency is 1 cycle: request seen at edge N, first beat possible in cycle N+1.
- GRANT, combinational outputs with owner g:
  - req_ready[g] = !w_full. All other req_ready bits are 0.
  - beat = req_valid[g] && !w_full.
  - w_en = beat.
  - w_data = req_data[g] whenever busy, else 0.
- GRANT, on each beat:
  - Burst counter increments.
  - release = req_last[g] || (counter == MAXBURST-1).
- GRANT, other release condition: req_valid[g]=0 in any cycle (owner went idle) releases with no beat.
- On release:
  - last_winner <= g, grant <= 0, busy <= 0, go to IDLE.
  - One idle bubble cycle always separates grants.
- w_full=1:
  - No beat and no counter change.
  - Grant is held indefinitely while req_valid[g] stays 1.
  - req_valid[g] falling while full still releases.
- Non-owner requesters must hold req_valid and data stable until served. The arbiter never drops or reorders beats within a requester.
- Counter width is clog2(MAXBURST)+1. For MAXBURST=1, every beat releases.
- Fairness: a continuously requesting requester waits at most (NREQ-1) grants.
- Simultaneous req_last and counter==MAXBURST-1 gives a single release with no double effect.
- Reset asserted mid-burst: the beat in the reset cycle is suppressed, and state returns to reset values at that edge.
- Requests arriving in the release cycle are seen in IDLE the next cycle.
- Invariants:
  - w_en implies !w_full.
  - popcount(grant) <= 1.
  - req_ready is one-hot or zero.

Test Plan:
1. Burst cap: MAXBURST=4; req 0 holds valid with data 10..15, last on 15, w_full=0 -> grant 0 at cycle 1, w_en on cycles 1-4 with 10..13, bubble, regrant, 14,15 written, release on last. Total 6 FIFO writes in order.
2. Round robin: all four valid continuously, each single-beat with last=1 -> grant_id sequence 0,1,2,3,0,1, busy toggling 1,0 each grant. No requester is granted twice before the others.
3. Full stall: req 2 granted; w_full=1 for 5 cycles mid-burst -> w_en=0 and req_ready=0 during stall, burst counter frozen. Burst resumes and completes its remaining beats after w_full falls, with no data loss or duplicate.
4. Owner idle: req 1 granted, sends 1 beat, drops valid without last -> release next edge, last_winner=1. Pending req 3 and req 0 are served in that order: 3 then 0.
5. Reset mid-burst: rst=1 during beat 2 of a grant to req 1 -> w_en=0 that cycle; grant=0, busy=0 after the edge. With all valid afterward, first grant is req 0.
6. Randomized: 4 requesters with random valid/last and random w_full, 2000 cycles -> per-requester scoreboard shows every accepted word in FIFO in order. Invariants hold: w_en implies !w_full, grant one-hot or zero, no burst exceeds 4 beats.
